// File: rtl/keypad_scanner_pkg.sv
// Keypad scanner shared types and helpers.
// Key codes, FSM states, key map and column decode.
package keypad_scanner_pkg;

  localparam logic [3:0] NO_KEY   = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  function automatic logic one_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) ||
           (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] row_idx(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'd0;
        default: return KEY_HASH;
      endcase
    end
    return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
  endfunction

  function automatic logic [1:0] col_next(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [2:0] col_drive(input logic [1:0] c);
    case (c)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset value is a parameter so idle-high lines reset high.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner with debounce.
// Drives digit codes on key; '*' and '#' give one-cycle pulses.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key,
  output logic       time_button,
  output logic       alarm_button
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [3:0] row_s;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk   (clock),
    .rst_n (reset),
    .d     (row_n),
    .q     (row_s)
  );

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    key_q, key_d;
  logic [2:0]    col_n_q, col_n_d;
  logic          tbtn_q, tbtn_d;
  logic          abtn_q, abtn_d;
  logic [3:0]    code;

  assign code = key_code(row_idx(pat_q), col_q);

  // Next-state: scan, debounce press, hold, debounce release.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    key_d   = key_q;
    tbtn_d  = 1'b0;
    abtn_d  = 1'b0;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low(row_s)) begin
            pat_d   = row_s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next(col_q);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_s == pat_q) begin
          if (cnt_q >= CNT_LAST) begin
            cnt_d   = '0;
            state_d = PRESSED;
            if (code == KEY_STAR)      tbtn_d = 1'b1;
            else if (code == KEY_HASH) abtn_d = 1'b1;
            else                       key_d  = code;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          div_d   = '0;
          col_d   = col_next(col_q);
          state_d = SCAN;
        end
      end
      PRESSED: begin
        if (row_s == 4'hF) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (row_s != 4'hF) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d   = '0;
          div_d   = '0;
          key_d   = NO_KEY;
          col_d   = col_next(col_q);
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
    col_n_d = col_drive(col_d);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      div_q   <= '0;
      col_q   <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= 4'hF;
      key_q   <= NO_KEY;
      col_n_q <= 3'b110;
      tbtn_q  <= 1'b0;
      abtn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      col_n_q <= col_n_d;
      tbtn_q  <= tbtn_d;
      abtn_q  <= abtn_d;
    end
  end

  assign col_n        = col_n_q;
  assign key          = key_q;
  assign time_button  = tbtn_q;
  assign alarm_button = abtn_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// A matrix model pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       time_button;
  logic       alarm_button;

  // Bit i = key at row i/3, column i%3.
  logic [11:0] pressed = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .row_n        (row_n),
    .col_n        (col_n),
    .key          (key),
    .time_button  (time_button),
    .alarm_button (alarm_button)
  );

  always_comb begin
    row_n = 4'hF;
    for (int i = 0; i < 12; i++)
      if (pressed[i] && !col_n[i % 3])
        row_n[i / 3] = 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_key(input logic [3:0] exp,
                          input int limit,
                          input string tag);
    int n = 0;
    while (key !== exp && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {28'd0, key}, {28'd0, exp});
  endtask

  task automatic watch(input int n, input logic [3:0] exp,
                       output int bad, output int tp, output int ap);
    bad = 0; tp = 0; ap = 0;
    repeat (n) begin
      @(negedge clock);
      if (key !== exp) bad++;
      if (time_button)  tp++;
      if (alarm_button) ap++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, tp, ap;
    cycles(10);
    chk("rst_col", {29'd0, col_n}, 32'b110);
    chk("rst_key", {28'd0, key}, 32'd10);
    chk("rst_tbtn", {31'd0, time_button}, 32'd0);
    chk("rst_abtn", {31'd0, alarm_button}, 32'd0);
    reset = 1'b1;
    cycles(3);
    chk("col0_hold", {29'd0, col_n}, 32'b110);
    cycles(1);
    chk("col1", {29'd0, col_n}, 32'b101);
    cycles(4);
    chk("col2", {29'd0, col_n}, 32'b011);
    cycles(4);
    chk("col0_wrap", {29'd0, col_n}, 32'b110);

    // '5' press, hold, release
    pressed[4] = 1'b1;
    wait_key(4'd5, 31, "k5_press");
    watch(70, 4'd5, bad, tp, ap);
    chk("k5_hold", bad, 0);
    chk("k5_no_pulse", tp + ap, 0);
    pressed = '0;
    watch(10, 4'd5, bad, tp, ap);
    chk("k5_rel_debounce", bad, 0);
    wait_key(4'd10, 9, "k5_release");

    // Bounce '8' from idle
    bad = 0;
    repeat (10) begin
      pressed[7] = ~pressed[7];
      @(negedge clock);
      if (key !== 4'd10) bad++;
    end
    pressed = '0;
    chk("k8_bounce_press", bad, 0);
    watch(40, 4'd10, bad, tp, ap);
    chk("k8_bounce_idle", bad, 0);

    // Held '8' with bouncy release
    pressed[7] = 1'b1;
    wait_key(4'd8, 31, "k8_press");
    watch(20, 4'd8, bad, tp, ap);
    chk("k8_hold", bad, 0);
    bad = 0;
    repeat (10) begin
      pressed[7] = ~pressed[7];
      @(negedge clock);
      if (key !== 4'd8) bad++;
    end
    chk("k8_bounce_release", bad, 0);
    pressed = '0;
    watch(12, 4'd8, bad, tp, ap);
    chk("k8_rel_debounce", bad, 0);
    wait_key(4'd10, 7, "k8_release");

    // '*' and '#'
    pressed[9] = 1'b1;
    watch(60, 4'd10, bad, tp, ap);
    chk("star_key", bad, 0);
    chk("star_tbtn", tp, 1);
    chk("star_abtn", ap, 0);
    pressed = '0;
    cycles(25);
    pressed[11] = 1'b1;
    watch(60, 4'd10, bad, tp, ap);
    chk("hash_key", bad, 0);
    chk("hash_abtn", ap, 1);
    chk("hash_tbtn", tp, 0);
    pressed = '0;
    cycles(25);

    // '2' and '5' together: same column, two rows
    pressed[1] = 1'b1;
    pressed[4] = 1'b1;
    watch(60, 4'd10, bad, tp, ap);
    chk("dual_key", bad, 0);
    chk("dual_pulse", tp + ap, 0);
    pressed = '0;
    cycles(5);

    // '2' then add '9'
    pressed[1] = 1'b1;
    wait_key(4'd2, 31, "k2_press");
    pressed[8] = 1'b1;
    watch(30, 4'd2, bad, tp, ap);
    chk("k2_extra_ignored", bad, 0);
    pressed = '0;
    wait_key(4'd10, 19, "k2_release");

    // Reset while PRESSED
    pressed[0] = 1'b1;
    wait_key(4'd1, 31, "k1_press");
    cycles(5);
    reset = 1'b0;
    #1;
    chk("midrst_key", {28'd0, key}, 32'd10);
    chk("midrst_col", {29'd0, col_n}, 32'b110);
    chk("midrst_pulse", {31'd0, time_button | alarm_button}, 32'd0);
    pressed = '0;
    cycles(3);
    reset = 1'b1;
    cycles(12);
    chk("post_rst_key", {28'd0, key}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
